// File: rtl/arm_pkg.sv
// Shared state encoding, bus-slicing and clamp helpers for the arm setpoint arbiter.
package arm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SWITCH = 2'd2
    } arb_state_e;

    // Bit offset of (source, channel) inside a flattened coordinate bus.
    function automatic int unsigned ch_lsb(input int unsigned src, input int unsigned ch,
                                           input int unsigned n_ch, input int unsigned w);
        return (src * n_ch + ch) * w;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/arm_setpoint_arbiter_channel.sv
// One coordinate channel: clamped target register and slew-limited position register.
module arm_slew_channel
    import arm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned STEP_MAX   = 8,
    parameter int          MIN_VAL    = -500,
    parameter int          MAX_VAL    = 500,
    parameter int          HOME_VAL   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  latch_en,
    input  logic                  step_en,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] pos,
    output logic                  at_target_c
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam logic signed [DW:0] STEP_S = (DW + 1)'(STEP_MAX);

    logic [DW-1:0]      tgt_q, tgt_d;
    logic [DW-1:0]      pos_q, pos_d;
    logic signed [DW:0] diff_c;

    // Step uses the target registered before this cycle's latch.
    always_comb begin
        tgt_d = tgt_q;
        pos_d = pos_q;
        if (latch_en) begin
            tgt_d = DW'(clamp(int'($signed(sample)), MIN_VAL, MAX_VAL));
        end
        diff_c = $signed({tgt_q[DW-1], tgt_q}) - $signed({pos_q[DW-1], pos_q});
        if (step_en) begin
            if (diff_c > STEP_S) begin
                pos_d = pos_q + DW'(STEP_MAX);
            end else if (diff_c < -STEP_S) begin
                pos_d = pos_q - DW'(STEP_MAX);
            end else begin
                pos_d = tgt_q;
            end
        end
        at_target_c = (pos_d == tgt_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_q <= DW'(HOME_VAL);
            pos_q <= DW'(HOME_VAL);
        end else begin
            tgt_q <= tgt_d;
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/arm_setpoint_arbiter.sv
// Source arbiter for the arm: picks a coordinate source, clamps and slew-limits each channel.
module arm_setpoint_arbiter
    import arm_pkg::*;
#(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned TICK_DIV   = 500_000,
    parameter int unsigned STEP_MAX   = 8,
    parameter int unsigned HOLD_TICKS = 25,
    parameter int          MIN_VAL    = -500,
    parameter int          MAX_VAL    = 500,
    parameter int          HOME_VAL   = 0,
    localparam int unsigned SEL_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [SEL_W-1:0]                   src_sel,
    input  logic [N_SRC*N_CH*DATA_WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]                   src_valid,
    output logic [N_CH*DATA_WIDTH-1:0]         pos_out,
    output logic                               pos_upd,
    output logic                               settled,
    output logic [SEL_W-1:0]                   active_src,
    output logic [1:0]                         state_out
);

    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    arb_state_e        state_q, state_d;
    logic [SEL_W-1:0]  active_q, active_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pos_upd_q, pos_upd_d;
    logic              settled_q, settled_d;
    logic              tick_c, switch_c, latch_c, step_c;
    logic [N_CH-1:0]   at_target_c;

    // A valid, different src_sel takes priority over sampling and stepping.
    always_comb begin
        tick_c   = (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d    = tick_c ? '0 : cnt_q + 1'b1;
        switch_c = enable && (32'(src_sel) < N_SRC) && (src_sel != active_q);

        state_d  = state_q;
        active_d = active_q;
        hold_d   = hold_q;
        latch_c  = 1'b0;
        step_c   = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else if (switch_c) begin
            state_d  = ST_SWITCH;
            active_d = src_sel;
            hold_d   = HOLD_W'(HOLD_TICKS);
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_TRACK;
                ST_TRACK: begin
                    latch_c = src_valid[active_q];
                    step_c  = tick_c;
                end
                ST_SWITCH: begin
                    if (tick_c) begin
                        hold_d = hold_q - 1'b1;
                        if (hold_q == HOLD_W'(1)) state_d = ST_TRACK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        pos_upd_d = step_c;
        settled_d = (state_d == ST_TRACK) && (&at_target_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            pos_upd_q <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            pos_upd_q <= pos_upd_d;
            settled_q <= settled_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] sample;

        always_comb begin
            sample = '0;
            for (int s = 0; s < N_SRC; s++) begin
                if (32'(active_q) == 32'(s)) begin
                    sample = src_data[ch_lsb(s, c, N_CH, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end

        arm_slew_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .STEP_MAX   (STEP_MAX),
            .MIN_VAL    (MIN_VAL),
            .MAX_VAL    (MAX_VAL),
            .HOME_VAL   (HOME_VAL)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .latch_en    (latch_c),
            .step_en     (step_c),
            .sample      (sample),
            .pos         (pos_out[c*DATA_WIDTH +: DATA_WIDTH]),
            .at_target_c (at_target_c[c])
        );
    end

    assign pos_upd    = pos_upd_q;
    assign settled    = settled_q;
    assign active_src = active_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_arm_setpoint_arbiter.sv
// Bench for arm_setpoint_arbiter: directed vector table, reset corner cases, random run vs. model.
module tb_arm_setpoint_arbiter;

    localparam int N_CH = 3;
    localparam int N_SRC = 3;
    localparam int DW = 10;
    localparam int TDIV = 4;
    localparam int STEP = 8;
    localparam int HOLD = 2;
    localparam int MINV = -500;
    localparam int MAXV = 500;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic [1:0]              src_sel;
    logic [N_SRC*N_CH*DW-1:0] src_data;
    logic [N_SRC-1:0]        src_valid;
    logic [N_CH*DW-1:0]      pos_out;
    logic                    pos_upd;
    logic                    settled;
    logic [1:0]              active_src;
    logic [1:0]              state_out;

    arm_setpoint_arbiter #(
        .N_CH(N_CH), .N_SRC(N_SRC), .DATA_WIDTH(DW), .TICK_DIV(TDIV), .STEP_MAX(STEP),
        .HOLD_TICKS(HOLD), .MIN_VAL(MINV), .MAX_VAL(MAXV), .HOME_VAL(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .src_sel(src_sel), .src_data(src_data),
        .src_valid(src_valid), .pos_out(pos_out), .pos_upd(pos_upd), .settled(settled),
        .active_src(active_src), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    int upd_cnt = 0;
    int sd[N_SRC][N_CH];

    // Reference model: 0=IDLE 1=TRACK 2=SWITCH, positions and targets as plain integers.
    int m_st, m_act, m_hold, m_cnt, m_upd, m_set;
    int m_pos[N_CH];
    int m_tgt[N_CH];

    typedef struct {
        bit en; int sel; int vld;
        int a0, a1, a2, b0, b1, b2;
        int n;
        int e0, e1, e2, est, eact, eset, eupd;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit en, int sel, int vld, int a0, int a1, int a2,
                                int b0, int b1, int b2, int n, int e0, int e1, int e2,
                                int est, int eact, int eset, int eupd);
        vec_t v;
        v.en = en; v.sel = sel; v.vld = vld;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.n = n; v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.est = est; v.eact = eact; v.eset = eset; v.eupd = eupd;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pos_of(input int c);
        logic [DW-1:0] v;
        v = pos_out[c*DW +: DW];
        return int'($signed(v));
    endfunction

    function automatic int clampi(input int v);
        return (v < MINV) ? MINV : ((v > MAXV) ? MAXV : v);
    endfunction

    function automatic int slew(input int p, input int t);
        if (t - p > STEP) return p + STEP;
        if (t - p < -STEP) return p - STEP;
        return t;
    endfunction

    task automatic drive();
        for (int s = 0; s < N_SRC; s++)
            for (int c = 0; c < N_CH; c++)
                src_data[(s*N_CH + c)*DW +: DW] = DW'(sd[s][c]);
    endtask

    task automatic model_reset();
        m_st = 0; m_act = 0; m_hold = 0; m_cnt = 0; m_upd = 0; m_set = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_pos[c] = 0;
            m_tgt[c] = 0;
        end
    endtask

    task automatic model_step();
        int  sel;
        bit  tick;
        int  np[N_CH];
        int  nt[N_CH];
        sel  = int'(src_sel);
        tick = (m_cnt == TDIV - 1);
        m_cnt = (m_cnt + 1) % TDIV;
        np = m_pos;
        nt = m_tgt;
        m_upd = 0;
        if (!enable) begin
            m_st = 0;
        end else if (sel < N_SRC && sel != m_act) begin
            m_st = 2; m_act = sel; m_hold = HOLD;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (tick) begin
                m_upd = 1;
                for (int c = 0; c < N_CH; c++) np[c] = slew(m_pos[c], m_tgt[c]);
            end
            if (src_valid[m_act])
                for (int c = 0; c < N_CH; c++) nt[c] = clampi(sd[m_act][c]);
        end else if (tick) begin
            m_hold--;
            if (m_hold == 0) m_st = 1;
        end
        m_pos = np;
        m_tgt = nt;
        m_set = (m_st == 1) ? 1 : 0;
        for (int c = 0; c < N_CH; c++)
            if (m_pos[c] != m_tgt[c]) m_set = 0;
    endtask

    // One clock with current inputs; every output is compared to the model afterwards.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        ncyc++;
        if (pos_upd) upd_cnt++;
        for (int c = 0; c < N_CH; c++)
            chk($sformatf("cyc%0d_pos%0d", ncyc, c), pos_of(c), m_pos[c]);
        chk($sformatf("cyc%0d_upd", ncyc), int'(pos_upd), m_upd);
        chk($sformatf("cyc%0d_settled", ncyc), int'(settled), m_set);
        chk($sformatf("cyc%0d_active", ncyc), int'(active_src), m_act);
        chk($sformatf("cyc%0d_state", ncyc), int'(state_out), m_st);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < N_CH; c++)
            chk($sformatf("%s_rst_pos%0d", tag, c), pos_of(c), 0);
        chk({tag, "_rst_state"}, int'(state_out), 0);
        chk({tag, "_rst_active"}, int'(active_src), 0);
        chk({tag, "_rst_upd"}, int'(pos_upd), 0);
        chk({tag, "_rst_settled"}, int'(settled), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        src_sel = 2'd0;
        src_valid = '0;
        for (int s = 0; s < N_SRC; s++)
            for (int c = 0; c < N_CH; c++) sd[s][c] = 0;
        drive();
        #2;
        apply_reset("init");

        //            en sel vld  src0            src1         n    pos             st act set upd
        tbl.push_back(mk(0, 0, 0,   0,    0, 0, -100, 0, 0,   8,   0,    0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1,  20,   -5, 3, -100, 0, 0,   4,   8,   -5, 3,  1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1,  20,   -5, 3, -100, 0, 0,   4,  16,   -5, 3,  1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1,  20,   -5, 3, -100, 0, 0,   4,  20,   -5, 3,  1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 3,  20,   -5, 3, -100, 0, 0,   4,  20,   -5, 3,  2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 3,  20,   -5, 3, -100, 0, 0,   4,  20,   -5, 3,  1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 3,  20,   -5, 3, -100, 0, 0,   4,  12,    0, 0,  1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 3,  20,   -5, 3, -100, 0, 0,   4,   4,    0, 0,  1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 3,  20,   -5, 3, -100, 0, 0,   4,  -4,    0, 0,  1, 1, 0, 1));
        tbl.push_back(mk(1, 2, 3,  20,   -5, 3, -100, 0, 0,   4,  -4,    0, 0,  2, 2, 0, 0));
        tbl.push_back(mk(1, 0, 3,  20,   -5, 3, -100, 0, 0,   4,  -4,    0, 0,  2, 0, 0, 0));
        tbl.push_back(mk(1, 3, 3,  20,   -5, 3, -100, 0, 0,   4,  -4,    0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1,  20,   -5, 3, -100, 0, 0,   4,   4,   -5, 3,  1, 0, 0, 1));
        tbl.push_back(mk(1, 3, 1, 511, -512, 0, -100, 0, 0,   4,  12,  -13, 0,  1, 0, 0, 1));
        tbl.push_back(mk(1, 3, 1, 511, -512, 0, -100, 0, 0, 240, 492, -493, 0,  1, 0, 0, 60));
        tbl.push_back(mk(1, 3, 1, 511, -512, 0, -100, 0, 0,   4, 500, -500, 0,  1, 0, 1, 1));
        tbl.push_back(mk(0, 3, 1, 511, -512, 0, -100, 0, 0,   4, 500, -500, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 460, -500, 0, -100, 0, 0,   4, 492, -500, 0,  1, 0, 0, 1));

        foreach (tbl[i]) begin
            enable = tbl[i].en;
            src_sel = 2'(tbl[i].sel);
            src_valid = 3'(tbl[i].vld);
            sd[0][0] = tbl[i].a0; sd[0][1] = tbl[i].a1; sd[0][2] = tbl[i].a2;
            sd[1][0] = tbl[i].b0; sd[1][1] = tbl[i].b1; sd[1][2] = tbl[i].b2;
            drive();
            upd_cnt = 0;
            repeat (tbl[i].n) cyc();
            chk($sformatf("row%0d_x", i), pos_of(0), tbl[i].e0);
            chk($sformatf("row%0d_y", i), pos_of(1), tbl[i].e1);
            chk($sformatf("row%0d_z", i), pos_of(2), tbl[i].e2);
            chk($sformatf("row%0d_state", i), int'(state_out), tbl[i].est);
            chk($sformatf("row%0d_active", i), int'(active_src), tbl[i].eact);
            chk($sformatf("row%0d_settled", i), int'(settled), tbl[i].eset);
            chk($sformatf("row%0d_upd_count", i), upd_cnt, tbl[i].eupd);
        end

        // Mid-ramp reset: ramp x toward 100, then pull reset between clock edges.
        apply_reset("pre_ramp");
        enable = 1'b1; src_sel = 2'd0; src_valid = 3'b001;
        sd[0][0] = 100; sd[0][1] = 0; sd[0][2] = 0;
        drive();
        repeat (20) cyc();
        chk("ramp_x40", pos_of(0), 40);
        enable = 1'b0;
        #2;
        apply_reset("mid_ramp");
        cyc();
        chk("post_rst_idle", int'(state_out), 0);
        chk("post_rst_home_x", pos_of(0), 0);

        // Random traffic against the model.
        apply_reset("rand");
        for (int i = 0; i < 3000; i++) begin
            int s, c, v;
            enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 39) == 0) src_sel = 2'($urandom_range(0, 3));
            src_valid = 3'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                s = int'($urandom_range(0, N_SRC - 1));
                c = int'($urandom_range(0, N_CH - 1));
                v = int'($urandom_range(0, 1023)) - 512;
                sd[s][c] = v;
            end
            drive();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
